// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: movement directions, game status,
// and the 180-degree reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    PAUSED       = 2'b00,
    PLAYING      = 2'b01,
    DIE_FLASHING = 2'b10,
    INITIALIZING = 2'b11
  } status_e;

  // Largest supported queue; storage is sized to this so indices stay 2 bits.
  localparam int MAX_DEPTH = 4;

  function automatic logic [1:0] opposite(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser, counter debouncer holding a stable level,
// and a one-cycle pulse on each accepted press (rising edge of stable).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic rise,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          toggle;

  // rise is the combinational "press accepted this edge", so the queue can
  // act on the same edge that pulse is registered.
  assign toggle = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = toggle && !stable;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, keeping the synchroniser chain two deep.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      pulse <= rise;
      if (sync2 == stable || toggle) cnt <= '0;
      else                           cnt <= cnt + 1'b1;
      if (toggle) stable <= ~stable;
    end
  end

endmodule

// File: rtl/direction_buffer.sv
// Debounces the four direction buttons and buffers accepted turns in a small
// queue that is drained one entry per snake step.
module direction_buffer
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DEPTH           = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       up,
  input  logic       right,
  input  logic       down,
  input  logic       left,
  input  logic       step,
  input  logic [1:0] game_status,
  output logic [1:0] current_direction,
  output logic [1:0] next_direction,
  output logic [3:0] key_pulse,
  output logic [2:0] queue_count
);

  logic [3:0] buttons;
  logic [3:0] rise;

  // Bit index equals the direction encoding: up=0, right=1, down=2, left=3.
  assign buttons = {left, down, right, up};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clock  (clock),
      .reset  (reset),
      .button (buttons[i]),
      .rise   (rise[i]),
      .pulse  (key_pulse[i])
    );
  end

  logic [1:0] mem   [MAX_DEPTH];
  logic [1:0] mem_n [MAX_DEPTH];
  logic [1:0] head, head_n;
  logic [2:0] count_n;
  logic [1:0] cur_n, next_n;
  logic [1:0] cand, ref_dir;
  logic       cand_valid, playing, accept;

  function automatic logic [1:0] wrap(input int idx);
    return 2'(idx % DEPTH);
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    mem_n   = mem;
    head_n  = head;
    count_n = queue_count;
    cur_n   = current_direction;

    cand_valid = |rise;
    cand       = DIR_UP;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) cand = 2'(i);
    end

    ref_dir = (queue_count != 3'd0)
            ? mem[wrap(int'(head) + int'(queue_count) - 1)]
            : current_direction;
    playing = (status_e'(game_status) == PLAYING);
    // A full queue still accepts when a step frees the head slot this cycle.
    accept  = playing && cand_valid && (cand != ref_dir) &&
              (cand != opposite(ref_dir)) &&
              ((queue_count < 3'(DEPTH)) || step);

    if (status_e'(game_status) == INITIALIZING) begin
      head_n  = 2'd0;
      count_n = 3'd0;
      cur_n   = DIR_RIGHT;
    end else if (playing) begin
      if (step && queue_count != 3'd0) begin
        cur_n   = mem[head];
        head_n  = wrap(int'(head) + 1);
        count_n = queue_count - 3'd1;
      end
      if (accept) begin
        if (step && queue_count == 3'd0) begin
          cur_n = cand;
        end else begin
          mem_n[wrap(int'(head) + int'(queue_count))] = cand;
          count_n = count_n + 3'd1;
        end
      end
    end

    next_n = (count_n != 3'd0) ? mem_n[head_n] : cur_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head              <= 2'd0;
      queue_count       <= 3'd0;
      current_direction <= DIR_RIGHT;
      next_direction    <= DIR_RIGHT;
    end else begin
      head              <= head_n;
      queue_count       <= count_n;
      current_direction <= cur_n;
      next_direction    <= next_n;
    end
  end

  // NOTE: queue storage has no reset; entries are only read below count,
  // which is reset, so stale contents are never observed.
  always_ff @(posedge clock) begin
    mem <= mem_n;
  end

endmodule

// File: tb/tb_direction_buffer.sv
// Self-checking bench for direction_buffer: directed scenarios with literal
// expectations, then randomized stimulus against a queue-level model.
module tb_direction_buffer;

  localparam int D     = 4;
  localparam int DEPTH = 2;

  logic       clock;
  logic       reset;
  logic [3:0] btn;
  logic       step;
  logic [1:0] status;
  logic [1:0] current_direction;
  logic [1:0] next_direction;
  logic [3:0] key_pulse;
  logic [2:0] queue_count;

  int checks   = 0;
  int failures = 0;

  direction_buffer #(.DEBOUNCE_CYCLES(D), .DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .up                (btn[0]),
    .right             (btn[1]),
    .down              (btn[2]),
    .left              (btn[3]),
    .step              (step),
    .game_status       (status),
    .current_direction (current_direction),
    .next_direction    (next_direction),
    .key_pulse         (key_pulse),
    .queue_count       (queue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a press is accepted once the synchronised level has
  // disagreed with the held level for the last D consecutive samples.
  bit         model_valid = 0;
  bit         hist [4][$];
  bit [3:0]   stable_m, s_m, d1_m, pulse_m;
  logic [1:0] dq [$];
  logic [1:0] cur_m;

  always @(posedge clock) begin
    bit [3:0]   rise_m;
    bit         all_diff;
    bit         valid;
    logic [1:0] cand, refd;
    bit         acc;
    if (reset) begin
      for (int b = 0; b < 4; b++) hist[b].delete();
      stable_m = '0; s_m = '0; d1_m = '0; pulse_m = '0;
      dq.delete();
      cur_m = 2'b01;
      model_valid = 1;
    end else begin
      rise_m = '0;
      for (int b = 0; b < 4; b++) begin
        hist[b].push_back(s_m[b]);
        if (hist[b].size() > D) void'(hist[b].pop_front());
        if (hist[b].size() == D) begin
          all_diff = 1;
          foreach (hist[b][j]) if (hist[b][j] == stable_m[b]) all_diff = 0;
          if (all_diff) begin
            if (!stable_m[b]) rise_m[b] = 1;
            stable_m[b] = !stable_m[b];
            hist[b].delete();
          end
        end
        s_m[b]  = d1_m[b];
        d1_m[b] = btn[b];
      end
      pulse_m = rise_m;

      valid = |rise_m;
      cand  = 2'b00;
      for (int i = 3; i >= 0; i--) if (rise_m[i]) cand = 2'(i);

      if (status == 2'b11) begin
        dq.delete();
        cur_m = 2'b01;
      end else if (status == 2'b01) begin
        refd = (dq.size() > 0) ? dq[$] : cur_m;
        acc  = valid && cand != refd && cand != (refd ^ 2'b10) &&
               (dq.size() < DEPTH || step);
        if (step) begin
          if (dq.size() > 0) begin
            cur_m = dq.pop_front();
            if (acc) dq.push_back(cand);
          end else if (acc) begin
            cur_m = cand;
          end
        end else if (acc) begin
          dq.push_back(cand);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("cur",       current_direction, cur_m);
      check("next",      next_direction, (dq.size() > 0) ? dq[0] : cur_m);
      check("key_pulse", key_pulse, pulse_m);
      check("count",     queue_count, dq.size());
    end
  end

  task automatic press(input int b, output bit seen);
    btn[b] = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (key_pulse[b]) seen = 1;
    end
    btn[b] = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic do_step();
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
  endtask

  task automatic init_play();
    status = 2'b11;
    @(negedge clock);
    status = 2'b01;
    @(negedge clock);
  endtask

  initial begin
    bit seen;
    int hold [4];
    reset = 1'b1; btn = '0; step = 1'b0; status = 2'b00;
    repeat (3) @(negedge clock);
    check("rst_cur",   current_direction, 2'b01);
    check("rst_next",  next_direction, 2'b01);
    check("rst_pulse", key_pulse, 4'b0000);
    check("rst_count", queue_count, 3'd0);
    reset = 1'b0;

    // Press latency: pulse on the 6th sampling point, exactly once.
    btn[0] = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clock);
      check("up_latency", key_pulse, (i == 6) ? 4'b0001 : 4'b0000);
      if (i == 10) btn[0] = 1'b0;
    end

    // Bounce shorter than the debounce window never produces a pulse.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn[1] = ~btn[1];
      @(negedge clock);
      check("bounce", key_pulse, 4'b0000);
    end
    btn[1] = 1'b0;
    repeat (8) begin
      @(negedge clock);
      check("bounce_tail", key_pulse, 4'b0000);
    end

    // Queue fill, full rejection, and drain by steps.
    init_play();
    check("init_cur", current_direction, 2'b01);
    press(2, seen);
    check("q1_count", queue_count, 3'd1);
    check("q1_next",  next_direction, 2'b10);
    press(3, seen);
    check("q2_count", queue_count, 3'd2);
    check("q2_next",  next_direction, 2'b10);
    press(0, seen);
    check("full_seen",  seen, 1'b1);
    check("full_count", queue_count, 3'd2);
    do_step();
    check("s1_cur",   current_direction, 2'b10);
    check("s1_count", queue_count, 3'd1);
    check("s1_next",  next_direction, 2'b11);
    do_step();
    check("s2_cur",   current_direction, 2'b11);
    check("s2_count", queue_count, 3'd0);

    // Opposite and duplicate rejection.
    init_play();
    press(3, seen);
    check("opp_count", queue_count, 3'd0);
    press(1, seen);
    check("dup_count", queue_count, 3'd0);
    check("dup_next",  next_direction, 2'b01);

    // Accepted press coincident with step bypasses the empty queue.
    init_play();
    btn[0] = 1'b1;
    repeat (5) @(negedge clock);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    check("byp_pulse", key_pulse, 4'b0001);
    check("byp_cur",   current_direction, 2'b00);
    check("byp_count", queue_count, 3'd0);
    btn[0] = 1'b0;
    repeat (8) @(negedge clock);

    // Initialising clears the queue; paused presses pulse but do not enqueue.
    init_play();
    press(2, seen);
    press(3, seen);
    check("pre_init_count", queue_count, 3'd2);
    status = 2'b11;
    @(negedge clock);
    check("clr_count", queue_count, 3'd0);
    check("clr_cur",   current_direction, 2'b01);
    status = 2'b00;
    press(0, seen);
    check("pause_seen",  seen, 1'b1);
    check("pause_count", queue_count, 3'd0);

    // Randomized phase checked against the model every cycle.
    status = 2'b01;
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          btn[b]  = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 12);
        end else begin
          hold[b]--;
        end
      end
      step = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 9))
          0:       status = 2'b00;
          1:       status = 2'b10;
          2:       status = 2'b11;
          default: status = 2'b01;
        endcase
      end
      @(negedge clock);
    end
    reset = 1'b0; btn = '0; step = 1'b0;
    repeat (20) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/direction_buffer.md
# direction_buffer

Input stage between the four raw direction buttons and the snake movement/FSM logic. It synchronises and debounces each button and emits one-cycle press pulses. Accepted presses go into a small direction queue that is consumed one entry per snake step. Presses that would reverse the snake 180° or repeat the queued direction are rejected, so fast key sequences survive slow game speeds.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- DEPTH, 2: direction queue capacity; legal range 1..4.

Ports:
- clock  in  1  system clock (100 MHz); single clock domain.
- reset  in  1  synchronous, active-high; the only reset.
- up, right, down, left  in  1 each  raw asynchronous button levels.
- step  in  1  one-cycle pulse, snake advances one cell this cycle.
- game_status  in  2  00 PAUSED, 01 PLAYING, 10 DIE_FLASHING, 11 INITIALIZING.
- current_direction  out  2  direction used by the last step; 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT.
- next_direction  out  2  queue head if the queue is non-empty, else current_direction.
- key_pulse  out  4  {left, down, right, up}, one-cycle debounced press pulses.
- queue_count  out  3  number of valid queue entries, 0..DEPTH.

## Operation
- Per button:
  - 2-flop synchroniser, then counter-based debouncer holding a `stable` level.
  - Counter clears whenever the synchronised level equals `stable`.
  - When the counter reaches DEBOUNCE_CYCLES−1 while the levels still differ, `stable` toggles and the counter clears.
  - Rising edge of `stable` → that bit of key_pulse high for exactly one cycle. Releases produce no pulse.
- Candidate selection: if several pulses occur in the same cycle, priority is up > right > down > left; only one candidate per cycle.
- Enqueue: only while game_status == 01.
  - Reference direction = queue tail if count > 0, else current_direction.
  - Reject if the candidate equals the reference or candidate == reference ^ 2'b10 (opposite).
  - Reject if count == DEPTH; the queue is never overwritten.
- Step: only while game_status == 01.
  - If count > 0: current_direction ← head, pop.
  - If count == 0: current_direction unchanged.
- Step and accepted candidate in the same cycle:
  - The reference is evaluated on the pre-step state.
  - If count == 0: the candidate bypasses the queue; current_direction ← candidate, count stays 0.
  - If count == DEPTH: pop and push both occur; count is unchanged.
- game_status == 11 (INITIALIZING): queue cleared, current_direction ← 01 (RIGHT). Debouncers keep running.
- game_status 00 / 10: queue and current_direction hold; step is ignored; pulses are still emitted.

## Timing
- Reset values:
  - current_direction = 01 and next_direction = 01.
  - key_pulse = 0, queue_count = 0.
  - All `stable` = 0, all counters = 0, synchronisers = 0.
- Press latency: a button first sampled high at edge k, held, gives key_pulse high during the cycle after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles. Exact, no jitter.
- Enqueue happens on the same edge that key_pulse is registered high; queue_count and next_direction update with it.
- Step takes effect on the edge where step is sampled high; current_direction is valid on the following cycle.
- All outputs are registered.
- Reset asserted mid-debounce or mid-queue: everything returns to reset values on that edge. A button still held after reset yields one pulse after a full debounce period.

## Structure
- Shared package snake_pkg:
  - Direction encodings DIR_UP/RIGHT/DOWN/LEFT.
  - Game-status encodings PAUSED/PLAYING/DIE_FLASHING/INITIALIZING.
  - Function opposite(dir) = dir ^ 2'b10.
- Sub-module key_debounce (synchroniser + counter + edge pulse), parameterised by DEBOUNCE_CYCLES, instantiated four times.
- Queue: DEPTH×2-bit register array with head/count pointers inside direction_buffer.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, DEPTH=2.
- Reset, then hold `up` for 10 cycles → key_pulse=0001 for exactly one cycle, 6 cycles after the first high sample; no pulse on release.
- Bounce: `right` toggles every 2 cycles for 20 cycles, then stays low → key_pulse stays 0.
- PLAYING, current=RIGHT; press down, then left, no step → queue_count=2, next_direction=DOWN. Press up → rejected, count stays 2. Step → current=DOWN, count=1. Step → current=LEFT, count=0.
- PLAYING, current=RIGHT; press left → rejected (opposite). Press right → rejected (duplicate). queue_count=0.
- count=0, accepted `up` pulse coincident with step → current_direction=UP next cycle, queue_count=0.
- Queue holds {DOWN, LEFT}, then game_status=11 for one cycle → queue_count=0, current_direction=RIGHT. With game_status=00, press up → pulse seen but count stays 0.
